// File: rtl/program_loader_pkg.sv
// Shared loader definitions: FSM state encodings and default port widths.
package program_loader_pkg;

  localparam int LD_ADDR_W  = 8;
  localparam int LD_INSTR_W = 16;
  localparam int LD_BYTE_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_WR   = 3'd4,
    S_CSUM = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_t;

endpackage

// File: rtl/program_loader_csum.sv
// XOR accumulator over the load stream; match compares the running XOR with din.
// Single-cycle update on en, clr has priority; no backpressure of its own.
module program_loader_csum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic         match
);

  logic [W-1:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

  assign match = (acc == din);

endmodule

// File: rtl/program_loader.sv
// Packs a high-byte-first byte stream into instruction words, writes them from address 0 and
// holds cpu_rst until the load completes; in_ready drops during WR, so at most one word per 3 cycles.
// Optional trailing checksum byte under LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W  = LD_ADDR_W,
  parameter int INSTR_W = LD_INSTR_W,
  parameter int BYTE_W  = LD_BYTE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [BYTE_W-1:0]  in_data,
  output logic               in_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_rst,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CNT_W = ADDR_W + 1;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  addr;
  logic [CNT_W-1:0]   count;
  logic [BYTE_W-1:0]  hi_byte;
  logic               xfer;
  logic               start_ok;
  logic               last;

  assign in_ready = (state == S_LEN) || (state == S_HI) || (state == S_LO) || (state == S_CSUM);
  assign xfer     = in_valid && in_ready;
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign last     = (count == CNT_W'(1));

  assign im_we   = (state == S_WR);
  assign im_addr = addr;
  assign busy    = (state == S_LEN) || (state == S_HI) || (state == S_LO) ||
                   (state == S_WR)  || (state == S_CSUM);
  assign done    = (state == S_DONE);
  assign cpu_rst = !done;

`ifdef LOADER_CHECKSUM_EN
  logic csum_ok;

  program_loader_csum #(.W(BYTE_W)) u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .en    (xfer && (state != S_CSUM)),
    .din   (in_data),
    .match (csum_ok)
  );

  assign err = (state == S_ERR);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN;
      S_LEN:  if (xfer) state_nxt = S_HI;
      S_HI:   if (xfer) state_nxt = S_LO;
      S_LO:   if (xfer) state_nxt = S_WR;
      S_WR: begin
        if (last) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: if (xfer) state_nxt = csum_ok ? S_DONE : S_ERR;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // A length byte of zero means a full memory image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      count    <= '0;
      hi_byte  <= '0;
      im_wdata <= '0;
    end else begin
      if (start_ok) begin
        addr <= '0;
      end
      if ((state == S_LEN) && xfer) begin
        count <= (in_data == '0) ? {1'b1, {ADDR_W{1'b0}}} : CNT_W'(in_data);
      end
      if ((state == S_HI) && xfer) begin
        hi_byte <= in_data;
      end
      if ((state == S_LO) && xfer) begin
        im_wdata <= INSTR_W'({hi_byte, in_data});
      end
      if (state == S_WR) begin
        addr  <= addr + ADDR_W'(1);
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard checked by a separate monitor.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [15:0] im_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  logic [23:0] sb[$];
  logic [23:0] exp_w;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  program_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && im_we) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL stray_write: got addr %0h data %0h, expected no write", im_addr, im_wdata);
      end else begin
        exp_w = sb.pop_front();
        check("wr_addr", {24'h0, im_addr}, {24'h0, exp_w[23:16]});
        check("wr_data", {16'h0, im_wdata}, {16'h0, exp_w[15:0]});
        check("wr_in_ready", {31'h0, in_ready}, 32'h0);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected byte %0h to be accepted", b);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_end;
    int n;
    n = 0;
    while (!(done || err) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL end_timeout: got done=%0b err=%0b, expected load to finish", done, err);
    end
  endtask

  task automatic check_done(input string p, input logic [7:0] last_addr);
    check({p, "_done"},    {31'h0, done},    32'h1);
    check({p, "_err"},     {31'h0, err},     32'h0);
    check({p, "_cpu_rst"}, {31'h0, cpu_rst}, 32'h0);
    check({p, "_busy"},    {31'h0, busy},    32'h0);
    check({p, "_addr"},    {24'h0, im_addr}, {24'h0, last_addr});
    check({p, "_sb_empty"}, sb.size(), 32'h0);
  endtask

  task automatic check_reset(input string p);
    check({p, "_in_ready"}, {31'h0, in_ready}, 32'h0);
    check({p, "_im_we"},    {31'h0, im_we},    32'h0);
    check({p, "_im_addr"},  {24'h0, im_addr},  32'h0);
    check({p, "_im_wdata"}, {16'h0, im_wdata}, 32'h0);
    check({p, "_cpu_rst"},  {31'h0, cpu_rst},  32'h1);
    check({p, "_busy"},     {31'h0, busy},     32'h0);
    check({p, "_done"},     {31'h0, done},     32'h0);
    check({p, "_err"},      {31'h0, err},      32'h0);
  endtask

  // Body of the reference two-word load: 02 12 34 56 78 [0A].
  task automatic stream1(input string p, input bit gaps);
    logic [7:0] s [5];
    s = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
    sb.push_back({8'h00, 16'h1234});
    sb.push_back({8'h01, 16'h5678});
    for (int i = 0; i < 5; i++) send_byte(s[i], gaps ? (i % 3) + 1 : 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h0A, gaps ? 2 : 0);
`endif
    wait_end();
    check_done(p, 8'h02);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_reset("rst");
    #10;
    rst_n = 1'b1;
    tick();

    // Test 1: basic load
    pulse_start();
    check("t1_busy",    {31'h0, busy},    32'h1);
    check("t1_cpu_rst", {31'h0, cpu_rst}, 32'h1);
    stream1("t1", 1'b0);

    // Test 2: idle gaps between bytes
    pulse_start();
    check("t2_done_clr", {31'h0, done}, 32'h0);
    stream1("t2", 1'b1);

    // Test 3: N=0, full 256-word image, addr wraps only after the final write
    pulse_start();
    for (int k = 0; k < 256; k++) begin
      sb.push_back({k[7:0], (2 * k) % 256 == 0 ? 8'h00 : 8'((2 * k) % 256), 8'((2 * k + 1) % 256)});
    end
    send_byte(8'h00, 0);
    for (int i = 0; i < 512; i++) send_byte(8'(i % 256), 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    wait_end();
    check_done("t3", 8'h00);

`ifdef LOADER_CHECKSUM_EN
    // Test 4: bad checksum
    pulse_start();
    sb.push_back({8'h00, 16'h1234});
    sb.push_back({8'h01, 16'h5678});
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    send_byte(8'hFF, 0);
    wait_end();
    check("t4_err",     {31'h0, err},     32'h1);
    check("t4_done",    {31'h0, done},    32'h0);
    check("t4_cpu_rst", {31'h0, cpu_rst}, 32'h1);
    check("t4_sb_empty", sb.size(), 32'h0);
    pulse_start();
    check("t4_err_clr", {31'h0, err},  32'h0);
    check("t4_busy",    {31'h0, busy}, 32'h1);
    stream1("t4b", 1'b0);
`endif

    // Test 5: reset mid-word, then a clean rerun
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    rst_n = 1'b0;
    #1;
    check_reset("t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pulse_start();
    stream1("t5", 1'b0);

    // Test 6: start while loading is ignored
    pulse_start();
    sb.push_back({8'h00, 16'h1234});
    sb.push_back({8'h01, 16'h5678});
    send_byte(8'h02, 0);
    pulse_start();
    check("t6_busy", {31'h0, busy},    32'h1);
    check("t6_addr", {24'h0, im_addr}, 32'h0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h0A, 0);
`endif
    wait_end();
    check_done("t6", 8'h02);

    repeat (4) tick();
    check("final_sb_empty", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
